// File: rtl/mdu_unit.sv
// mdu_unit: execute-stage multiply/divide unit owning the HI/LO registers.
// Fixed-latency and non-pipelined: one compute op in flight at a time, with a
// 4-bit down-counter that commits the pending result when it reaches 1.
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU (ops 9/10);
// when undefined those encodings decode as NONE.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no op in flight; compute ops may start, MTHI/MTLO may write
// ST_BUSY | op in flight; cnt_q counts down, result commits at cnt_q==1
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [3:0]  mdu_op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        req_i,
    output logic        start_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] rd_data_o
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
    localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] hi_p_q, hi_p_d, lo_p_q, lo_p_d;

    logic        is_compute, is_div;
    logic [63:0] prod_s, prod_u, result;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, q_u, r_u;

    // Decode which encodings are compute ops and which latency class they use.
    always_comb begin
        is_div     = (mdu_op_i == OP_DIV) || (mdu_op_i == OP_DIVU);
        is_compute = (mdu_op_i == OP_MULT) || (mdu_op_i == OP_MULTU) || is_div;
`ifdef MDU_MADD_EN
        is_compute = is_compute || (mdu_op_i == OP_MADD) || (mdu_op_i == OP_MADDU);
`endif
    end

    assign start_o = is_compute && !req_i && (state_q == ST_IDLE);
    assign busy_o  = (state_q == ST_BUSY);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    // Zero-latency read port for MFHI/MFLO.
    always_comb begin
        rd_data_o = 32'd0;
        if (mdu_op_i == OP_MFHI) rd_data_o = hi_q;
        if (mdu_op_i == OP_MFLO) rd_data_o = lo_q;
    end

    // Result datapath; signed divide works on magnitudes and restores signs
    // so that 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
    always_comb begin
        prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
        prod_u = {32'd0, a_i} * {32'd0, b_i};
        a_mag  = a_i[31] ? (32'd0 - a_i) : a_i;
        b_mag  = b_i[31] ? (32'd0 - b_i) : b_i;
        q_mag  = 32'd0;
        r_mag  = 32'd0;
        q_u    = 32'd0;
        r_u    = 32'd0;
        if (b_i != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            q_u   = a_i / b_i;
            r_u   = a_i % b_i;
        end
        result = {hi_q, lo_q};
        case (mdu_op_i)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV: begin
                if (b_i != 32'd0) begin
                    result[31:0]  = (a_i[31] ^ b_i[31]) ? (32'd0 - q_mag) : q_mag;
                    result[63:32] = a_i[31] ? (32'd0 - r_mag) : r_mag;
                end
            end
            OP_DIVU: begin
                if (b_i != 32'd0) result = {r_u, q_u};
            end
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi_q, lo_q} + prod_s;
            OP_MADDU: result = {hi_q, lo_q} + prod_u;
`endif
            default:  result = {hi_q, lo_q};
        endcase
    end

    // Next-state: start capture, countdown/commit, and MTHI/MTLO writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_p_d  = hi_p_q;
        lo_p_d  = lo_p_q;
        case (state_q)
            ST_IDLE: begin
                if (start_o) begin
                    state_d = ST_BUSY;
                    cnt_d   = is_div ? DIV_N : MULT_N;
                    hi_p_d  = result[63:32];
                    lo_p_d  = result[31:0];
                end else if (!req_i) begin
                    if (mdu_op_i == OP_MTHI) hi_d = a_i;
                    if (mdu_op_i == OP_MTLO) lo_d = a_i;
                end
            end
            ST_BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    hi_d    = hi_p_q;
                    lo_d    = lo_p_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset discards any pending result.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_p_q  <= 32'd0;
            lo_p_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_p_q  <= hi_p_d;
            lo_p_q  <= lo_p_d;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit with a behavioural HI/LO reference model.
module tb_mdu_unit;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mdu_op;
    logic [31:0] a_in, b_in;
    logic        req;
    logic        start, busy;
    logic [31:0] hi, lo, rd_data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_hi, m_lo;

    mdu_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
        .clk_i(clk), .reset_i(reset), .mdu_op_i(mdu_op), .a_i(a_in), .b_i(b_in),
        .req_i(req), .start_o(start), .busy_o(busy), .hi_o(hi), .lo_o(lo),
        .rd_data_o(rd_data)
    );

    always #5 clk = ~clk;

`ifdef MDU_MADD_EN
    localparam bit MADD_ON = 1'b1;
`else
    localparam bit MADD_ON = 1'b0;
`endif

    function automatic bit is_comp(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) || (MADD_ON && (op == 4'd9 || op == 4'd10));
    endfunction

    function automatic int lat(input logic [3:0] op);
        return (op == 4'd3 || op == 4'd4) ? N_DIV : N_MULT;
    endfunction

    // Architectural meaning of each compute op as plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a, b,
                                               input logic [31:0] h, l);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 32'd0) return {h, l};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {h, l};
                return {a % b, a / b};
            end
            4'd9:  return {h, l} + 64'(sa * sb);
            4'd10: return {h, l} + ua * ub;
            default: return {h, l};
        endcase
    endfunction

    // The hazard controller never presents a compute op while busy.
    always @(posedge clk) begin
        if (!reset && busy === 1'b1 && is_comp(mdu_op)) begin
            n_fail++;
            $display("FAIL op_while_busy: op=%0d presented while busy", mdu_op);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, b, input logic r,
                         output logic st, output logic [31:0] rd, output int ncyc);
        @(negedge clk);
        mdu_op = op; a_in = a; b_in = b; req = r;
        #1;
        st = start;
        rd = rd_data;
        @(negedge clk);
        mdu_op = 4'd0; req = 1'b0;
        ncyc = 0;
        while (busy === 1'b1 && ncyc < 40) begin
            ncyc++;
            @(negedge clk);
        end
    endtask

    // Applies the architectural effect of an accepted op to the model.
    task automatic model_apply(input logic [3:0] op, input logic [31:0] a, b, input logic r);
        logic [63:0] res;
        if (r) return;
        if (is_comp(op)) begin
            res = ref_result(op, a, b, m_hi, m_lo);
            m_hi = res[63:32];
            m_lo = res[31:0];
        end else if (op == 4'd7) m_hi = a;
        else if (op == 4'd8) m_lo = a;
    endtask

    task automatic test_reset();
        reset = 1'b1; mdu_op = 4'd0; a_in = '0; b_in = '0; req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        n_cmp++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", start); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", rd_data); end
    endtask

    task automatic test_mult();
        logic st; logic [31:0] rd; int nc;
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, st, rd, nc);
        n_cmp++; if (st !== 1'b1) begin n_fail++; $display("FAIL mult_start: got %b want 1", st); end
        n_cmp++; if (nc != N_MULT) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want %0d", nc, N_MULT); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
        mdu_op = 4'd5;
        #1;
        n_cmp++; if (rd_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_mfhi: got %h want ffffffff", rd_data); end
        mdu_op = 4'd6;
        #1;
        n_cmp++; if (rd_data !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_mflo: got %h want fffffffa", rd_data); end
        mdu_op = 4'd0;
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFA;
    endtask

    task automatic test_div();
        logic st; logic [31:0] rd; int nc;
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, st, rd, nc);
        n_cmp++; if (nc != N_DIV) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want %0d", nc, N_DIV); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, st, rd, nc);
        n_cmp++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_fail++; $display("FAIL div_ovf_hi: got %h want 0", hi); end
        issue(4'd8, 32'h1234, 32'd0, 1'b0, st, rd, nc);
        issue(4'd7, 32'h5678, 32'd0, 1'b0, st, rd, nc);
        n_cmp++; if (lo !== 32'h1234 || hi !== 32'h5678) begin
            n_fail++; $display("FAIL mt_write: got hi=%h lo=%h want hi=5678 lo=1234", hi, lo); end
        issue(4'd4, 32'd7, 32'd0, 1'b0, st, rd, nc);
        n_cmp++; if (st !== 1'b1) begin n_fail++; $display("FAIL divz_start: got %b want 1", st); end
        n_cmp++; if (nc != N_DIV) begin n_fail++; $display("FAIL divz_busy_cycles: got %0d want %0d", nc, N_DIV); end
        n_cmp++; if (lo !== 32'h1234 || hi !== 32'h5678) begin
            n_fail++; $display("FAIL divz_keep: got hi=%h lo=%h want hi=5678 lo=1234", hi, lo); end
        m_hi = 32'h5678; m_lo = 32'h1234;
    endtask

    task automatic test_mt_timing();
        @(negedge clk);
        mdu_op = 4'd7; a_in = 32'hCAFE_0001; req = 1'b0;
        @(negedge clk);
        mdu_op = 4'd5;
        #1;
        n_cmp++; if (rd_data !== 32'hCAFE_0001) begin n_fail++; $display("FAIL mthi_mfhi: got %h want cafe0001", rd_data); end
        mdu_op = 4'd0;
        m_hi = 32'hCAFE_0001;
    endtask

    task automatic test_req();
        logic st; logic [31:0] rd; int nc;
        issue(4'd1, 32'd9, 32'd9, 1'b1, st, rd, nc);
        n_cmp++; if (st !== 1'b0) begin n_fail++; $display("FAIL req_start: got %b want 0", st); end
        n_cmp++; if (nc != 0) begin n_fail++; $display("FAIL req_busy: got %0d cycles want 0", nc); end
        n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
            n_fail++; $display("FAIL req_mult_keep: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, m_hi, m_lo); end
        issue(4'd7, 32'hAAAA, 32'd0, 1'b1, st, rd, nc);
        n_cmp++; if (hi !== m_hi) begin n_fail++; $display("FAIL req_mthi_keep: got %h want %h", hi, m_hi); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mdu_op = 4'd1; a_in = 32'd3; b_in = 32'd4; req = 1'b0;
        @(negedge clk);
        mdu_op = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_clear: got hi=%h lo=%h want 0/0", hi, lo); end
        repeat (8) @(negedge clk);
        n_cmp++; if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_no_commit: got hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy); end
    endtask

    task automatic test_back_to_back();
        logic st; logic [31:0] rd; int nc;
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, st, rd, nc);
        mdu_op = 4'd4; a_in = 32'd10; b_in = 32'd3;
        #1;
        n_cmp++; if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL b2b_multu: got hi=%h lo=%h want 1/fffffffe", hi, lo); end
        n_cmp++; if (start !== 1'b1) begin n_fail++; $display("FAIL b2b_start: got %b want 1", start); end
        @(negedge clk);
        mdu_op = 4'd0;
        nc = 0;
        while (busy === 1'b1 && nc < 40) begin nc++; @(negedge clk); end
        n_cmp++; if (nc != N_DIV) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want %0d", nc, N_DIV); end
        n_cmp++; if (lo !== 32'd3 || hi !== 32'd1) begin
            n_fail++; $display("FAIL b2b_divu: got hi=%h lo=%h want 1/3", hi, lo); end
        m_hi = 32'd1; m_lo = 32'd3;
    endtask

    task automatic test_madd();
        logic st; logic [31:0] rd; int nc;
        issue(4'd8, 32'd5, 32'd0, 1'b0, st, rd, nc);
        issue(4'd7, 32'd0, 32'd0, 1'b0, st, rd, nc);
        m_hi = 32'd0; m_lo = 32'd5;
        issue(4'd9, 32'd2, 32'd3, 1'b0, st, rd, nc);
        if (MADD_ON) begin
            n_cmp++; if (st !== 1'b1 || nc != N_MULT) begin
                n_fail++; $display("FAIL madd_timing: got start=%b cycles=%0d want 1/%0d", st, nc, N_MULT); end
            n_cmp++; if (lo !== 32'd11 || hi !== 32'd0) begin
                n_fail++; $display("FAIL madd_result: got hi=%h lo=%h want 0/11", hi, lo); end
            m_lo = 32'd11;
        end else begin
            n_cmp++; if (st !== 1'b0 || nc != 0) begin
                n_fail++; $display("FAIL madd_off_start: got start=%b cycles=%0d want 0/0", st, nc); end
            n_cmp++; if (lo !== 32'd5 || hi !== 32'd0) begin
                n_fail++; $display("FAIL madd_off_keep: got hi=%h lo=%h want 0/5", hi, lo); end
        end
    endtask

    task automatic test_random();
        logic st; logic [31:0] rd; int nc;
        logic [3:0] op; logic [31:0] a, b, exp_rd; logic r;
        bit exp_st; int exp_nc;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) op = 4'($urandom_range(1, 4));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            r = ($urandom_range(0, 7) == 0);
            exp_st = is_comp(op) && !r;
            exp_nc = exp_st ? lat(op) : 0;
            exp_rd = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
            issue(op, a, b, r, st, rd, nc);
            model_apply(op, a, b, r);
            n_cmp++; if (st !== exp_st) begin
                n_fail++; $display("FAIL rnd_start[%0d]: op=%0d got %b want %b", i, op, st, exp_st); end
            n_cmp++; if (nc != exp_nc) begin
                n_fail++; $display("FAIL rnd_cycles[%0d]: op=%0d got %0d want %0d", i, op, nc, exp_nc); end
            n_cmp++; if (rd !== exp_rd) begin
                n_fail++; $display("FAIL rnd_rd[%0d]: op=%0d got %h want %h", i, op, rd, exp_rd); end
            n_cmp++; if (hi !== m_hi || lo !== m_lo) begin
                n_fail++; $display("FAIL rnd_hilo[%0d]: op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
                                   i, op, a, b, hi, lo, m_hi, m_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_timing();
        test_req();
        test_reset_mid();
        test_back_to_back();
        test_madd();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
